vga_output_stage: RTL

Downstream of the VGA controller, on clk_25. Takes the controller's 6-bit colour and raw sync outputs and aligns sync to the registered colour. Expands colour to the 12-bit (4:4:4) VGA connector format and verifies 640x480@60 line and frame timing with a lock state machine. Colour is gated to black outside the active window and whenever timing is not locked; frame and error counters are exported for debug.

---
 rtl/vga_output_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_output_stage.sv
// VGA output stage: aligns raw sync to registered colour, expands 6-bit colour to 4:4:4,
// and gates colour on a 640x480@60 timing lock with debug frame/error counters.
module vga_output_stage #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_START         = 144,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_START         = 35,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned SYNC_DELAY      = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [5:0]  rgb_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam logic       SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
  localparam logic [9:0] H_BEGIN   = 10'(H_START);
  localparam logic [9:0] H_END     = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_BEGIN   = 10'(V_START);
  localparam logic [9:0] V_END     = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX   = 10'h3FF;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic hs_a, vs_a;

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_a = hsync_in;
      assign vs_a = vsync_in;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;
      always_ff @(posedge clk_25) begin
        if (reset) begin
          hs_pipe <= {SYNC_DELAY{SYNC_IDLE}};
          vs_pipe <= {SYNC_DELAY{SYNC_IDLE}};
        end else begin
          hs_pipe[0] <= hsync_in;
          vs_pipe[0] <= vsync_in;
          for (int i = 1; i < int'(SYNC_DELAY); i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end
      assign hs_a = hs_pipe[SYNC_DELAY-1];
      assign vs_a = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  logic        hs_prev_q, vs_edge_q;
  logic [9:0]  h_cnt_q, h_cnt_d, line_idx_q, line_idx_d, h_pos;
  logic [1:0]  state_q, state_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [3:0]  vga_r_q, vga_g_q, vga_b_q;
  logic        vga_hs_q, vga_vs_q;

  logic hs_act, vs_act, hs_edge, frame_start, line_err, frame_err, checking, any_err, active;
  logic [1:0] n_err;
  logic [8:0] err_sum;

  always_comb begin
    hs_act      = (hs_a != SYNC_IDLE);
    vs_act      = (vs_a != SYNC_IDLE);
    hs_edge     = hs_act && !hs_prev_q;
    frame_start = hs_edge && vs_act && !vs_edge_q;
    h_pos       = hs_edge ? 10'd0 : h_cnt_q;

    h_cnt_d = hs_edge ? 10'd1 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
    if (frame_start)                        line_idx_d = 10'd0;
    else if (hs_edge && line_idx_q != CNT_MAX) line_idx_d = line_idx_q + 10'd1;
    else                                    line_idx_d = line_idx_q;

    // h_cnt_q == 1022 without an edge is the cycle the counter reaches its ceiling
    line_err  = (hs_edge && (h_cnt_q != H_TOTAL_W)) || (!hs_edge && (h_cnt_q == CNT_MAX - 10'd1));
    frame_err = frame_start && (line_idx_q != V_LAST);
    checking  = (state_q == ST_CHECK) || (state_q == ST_LOCKED);
    any_err   = checking && (line_err || frame_err);
    n_err     = checking ? ({1'b0, line_err} + {1'b0, frame_err}) : 2'd0;
    err_sum   = {1'b0, err_count_q} + {7'd0, n_err};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];

    // An error in CHECK restarts the window: a later error-free frame start is needed to lock
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (frame_start) state_d = ST_CHECK;
      ST_CHECK:    if (!any_err && frame_start) state_d = ST_LOCKED;
      ST_LOCKED:   if (any_err) state_d = ST_UNLOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase

    frame_count_d = (state_q == ST_LOCKED && frame_start) ? frame_count_q + 16'd1 : frame_count_q;

    active = (h_pos >= H_BEGIN) && (h_pos < H_END) &&
             (line_idx_q >= V_BEGIN) && (line_idx_q < V_END);
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_edge_q     <= 1'b0;
      h_cnt_q       <= 10'd0;
      line_idx_q    <= 10'd0;
      state_q       <= ST_UNLOCKED;
      frame_count_q <= 16'd0;
      err_count_q   <= 8'd0;
      vga_r_q       <= 4'd0;
      vga_g_q       <= 4'd0;
      vga_b_q       <= 4'd0;
      vga_hs_q      <= SYNC_IDLE;
      vga_vs_q      <= SYNC_IDLE;
    end else begin
      hs_prev_q     <= hs_act;
      if (hs_edge) vs_edge_q <= vs_act;
      h_cnt_q       <= h_cnt_d;
      line_idx_q    <= line_idx_d;
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      // Gate on the next state so colour drops in the same clock locked does
      if (state_d == ST_LOCKED && active) begin
        vga_r_q <= {rgb_in[5:4], rgb_in[5:4]};
        vga_g_q <= {rgb_in[3:2], rgb_in[3:2]};
        vga_b_q <= {rgb_in[1:0], rgb_in[1:0]};
      end else begin
        vga_r_q <= 4'd0;
        vga_g_q <= 4'd0;
        vga_b_q <= 4'd0;
      end
      vga_hs_q      <= hs_a;
      vga_vs_q      <= vs_a;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign locked      = (state_q == ST_LOCKED);
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule
